csync_gen: RTL and testbench



---
 rtl/csync_pkg.sv | 6 +
 rtl/sync_measure.sv | 45 ++++
 rtl/csync_gen.sv | 55 +++++
 tb/tb_csync_gen.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/csync_pkg.sv
// csync_pkg: shared constants and FSM state type for the composite-sync generator
package csync_pkg;
  localparam int DEF_HCNT_W = 12;
  localparam int CSYNC_LAT = 2;
  typedef enum logic [1:0] {NOLOCK, LINE, VBROAD, VSERR} csync_state_t;
endpackage

// File: rtl/sync_measure.sv
// sync_measure: hsync edge detection plus line-length and hsync-width measurement
module sync_measure import csync_pkg::*; #(
  parameter int HCNT_W = DEF_HCNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              hsync,
  output logic              hs_rise,
  output logic [HCNT_W-1:0] hcnt,
  output logic [HCNT_W-1:0] line_len,
  output logic [HCNT_W-1:0] hs_len,
  output logic              len_ok
);
  logic hs_prev, hs_fall, seen, ok_q, hcnt_sat;
  logic [HCNT_W-1:0] hs_w;
  assign hs_rise  = ce_pix & hsync & ~hs_prev;
  assign hs_fall  = ce_pix & ~hsync & hs_prev;
  assign hcnt_sat = &hcnt;
  assign len_ok   = ok_q & (hs_len < line_len);
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev  <= 1'b0;
      seen     <= 1'b0;
      ok_q     <= 1'b0;
      hcnt     <= '0;
      hs_w     <= '0;
      line_len <= '0;
      hs_len   <= '0;
    end else begin
      if (ce_pix) hs_prev <= hsync;
      if (hs_rise) begin
        hcnt <= HCNT_W'(1);
        hs_w <= HCNT_W'(1);
        seen <= 1'b1;
        ok_q <= seen & ~hcnt_sat;
        if (!hcnt_sat) line_len <= hcnt;
      end else if (ce_pix) begin
        if (!hcnt_sat) hcnt <= hcnt + HCNT_W'(1);
        if (hsync && !(&hs_w)) hs_w <= hs_w + HCNT_W'(1);
      end
      if (hs_fall) hs_len <= hs_w;
    end
  end
endmodule

// File: rtl/csync_gen.sv
// csync_gen: composite-sync generator with XOR or measured broad-pulse serrations, pixel-aligned outputs
module csync_gen import csync_pkg::*; #(
  parameter int HCNT_W = DEF_HCNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  input  logic [23:0] din,
  input  logic        serr_en,
  output logic [23:0] dout,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        csync_o,
  output logic        de_o
);
  csync_state_t state, state_n;
  logic hs_rise, len_ok, cs;
  logic [HCNT_W-1:0] hcnt, line_len, hs_len;
  logic [CSYNC_LAT-1:0][27:0] pipe;
  sync_measure #(.HCNT_W(HCNT_W)) u_meas (
    .clk      (clk),
    .reset    (reset),
    .ce_pix   (ce_pix),
    .hsync    (hsync),
    .hs_rise  (hs_rise),
    .hcnt     (hcnt),
    .line_len (line_len),
    .hs_len   (hs_len),
    .len_ok   (len_ok)
  );
  always_comb begin
    state_n = (!len_ok || !serr_en) ? NOLOCK :
              (state == NOLOCK)     ? LINE :
              (state == LINE)       ? (vsync ? VBROAD : LINE) :
              !vsync                ? LINE :
              (state == VBROAD)     ? ((ce_pix && hcnt == line_len - hs_len) ? VSERR : VBROAD) :
              (hs_rise ? VBROAD : VSERR);
    cs = (state == NOLOCK) ? hsync ^ vsync :
         (state == LINE)   ? hsync :
         (state == VBROAD);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= NOLOCK;
      pipe  <= '0;
    end else begin
      state <= state_n;
      pipe  <= {pipe[CSYNC_LAT-2:0], {cs, hsync, vsync, de, din}};
    end
  end
  assign {csync_o, hsync_o, vsync_o, de_o, dout} = pipe[CSYNC_LAT-1];
endmodule

// File: tb/tb_csync_gen.sv
// tb_csync_gen: directed stimulus against a timestamp-based behavioural model of csync_gen
module tb_csync_gen;
  import csync_pkg::*;
  logic clk = 1'b0, reset = 1'b1, ce_pix = 1'b0, hsync = 1'b0, vsync = 1'b0, de = 1'b0, serr_en = 1'b0;
  logic [23:0] din = '0, dout;
  logic hsync_o, vsync_o, csync_o, de_o;
  int checks = 0, failures = 0, low_cnt = 0, cediv = 1;
  bit chk_en = 1'b0, cnt_en = 1'b0;
  logic [27:0] exp_q [2];
  csync_gen #(.HCNT_W(12)) dut (
    .clk     (clk),
    .reset   (reset),
    .ce_pix  (ce_pix),
    .hsync   (hsync),
    .vsync   (vsync),
    .de      (de),
    .din     (din),
    .serr_en (serr_en),
    .dout    (dout),
    .hsync_o (hsync_o),
    .vsync_o (vsync_o),
    .csync_o (csync_o),
    .de_o    (de_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask
  // Model: lengths come from pixel timestamps of hsync edges; output mode from the sync rules.
  initial begin : model
    int pix, rise_pix, m_len, m_hslen, hc;
    bit seen, m_ok, prev_h, lk, vb, gap, rise, fall, ok;
    exp_q[0] = '0;
    exp_q[1] = '0;
    {pix, rise_pix, m_len, m_hslen} = '0;
    {seen, m_ok, prev_h, lk, vb, gap} = '0;
    forever begin
      @(posedge clk);
      hc   = (pix - rise_pix > 4095) ? 4095 : pix - rise_pix;
      rise = ce_pix && hsync && !prev_h;
      fall = ce_pix && !hsync && prev_h;
      ok   = m_ok && (m_hslen < m_len);
      exp_q[1] = exp_q[0];
      exp_q[0] = {(!lk ? hsync ^ vsync : !vb ? hsync : !gap), hsync, vsync, de, din};
      if (reset) begin
        exp_q[0] = '0;
        exp_q[1] = '0;
        {pix, rise_pix, m_len, m_hslen} = '0;
        {seen, m_ok, prev_h, lk, vb, gap} = '0;
      end else begin
        if (!(ok && serr_en)) {lk, vb, gap} = 3'b000;
        else if (!lk) {lk, vb, gap} = 3'b100;
        else if (!vb) vb = vsync;
        else if (!vsync) {vb, gap} = 2'b00;
        else if (!gap) gap = ce_pix && (hc == m_len - m_hslen);
        else gap = !rise;
        if (rise) begin
          m_ok = seen && hc != 4095;
          if (hc != 4095) m_len = hc;
          seen = 1'b1;
          rise_pix = pix;
        end
        if (fall) m_hslen = pix - rise_pix;
        if (ce_pix) begin
          prev_h = hsync;
          pix++;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (chk_en) chk("pipe", {csync_o, hsync_o, vsync_o, de_o, dout}, exp_q[1]);
    if (cnt_en && csync_o === 1'b0) low_cnt++;
  end
  task automatic pixel(input bit h, input bit v);
    for (int k = 0; k < cediv; k++) begin
      @(posedge clk);
      #1;
      ce_pix = (k == 0);
      hsync  = h;
      vsync  = v;
      de     = 1'($urandom);
      din    = 24'($urandom);
    end
  endtask
  task automatic line(input int len, input int hw, input bit v);
    for (int p = 0; p < len; p++) pixel(p < hw, v);
  endtask
  task automatic window(input int len, input int hw, input int want, input string nm);
    low_cnt = 0;
    cnt_en = 1'b1;
    line(len, hw, 1'b1);
    cnt_en = 1'b0;
    chk(nm, 64'(low_cnt), 64'(want));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #1;
    chk("rst_csync", csync_o, 0);
    chk("rst_dout", dout, 0);
    chk("rst_de", de_o, 0);
    chk("rst_state", dut.state, NOLOCK);
    chk("rst_line_len", dut.u_meas.line_len, 0);
    reset = 1'b0;
    repeat (3) line(100, 8, 1'b0);
    chk("line_len_100", dut.u_meas.line_len, 100);
    chk("hs_len_8", dut.u_meas.hs_len, 8);
    chk("xor_state", dut.state, NOLOCK);
    serr_en = 1'b1;
    repeat (2) line(100, 8, 1'b0);
    chk("lock_state", dut.state, LINE);
    line(100, 8, 1'b1);
    chk("vserr_state", dut.state, VSERR);
    window(100, 8, 8, "serr_gap_px");
    line(100, 8, 1'b1);
    repeat (2) line(100, 8, 1'b0);
    serr_en = 1'b0;
    line(100, 8, 1'b1);
    window(100, 8, 8, "xor_low_px");
    line(100, 8, 1'b1);
    chk("serr_off_state", dut.state, NOLOCK);
    repeat (2) line(100, 8, 1'b0);
    serr_en = 1'b1;
    for (int i = 0; i < 4200; i++) pixel(1'b0, 1'b0);
    chk("hcnt_sat", dut.u_meas.hcnt, 12'hfff);
    line(100, 8, 1'b0);
    chk("sat_len_ok", dut.u_meas.len_ok, 0);
    chk("sat_state", dut.state, NOLOCK);
    line(100, 8, 1'b0);
    chk("relock_state", dut.state, LINE);
    chk("relock_len", dut.u_meas.line_len, 100);
    line(100, 8, 1'b1);
    for (int p = 0; p < 96; p++) pixel(p < 8, 1'b1);
    chk("pre_rst_vserr", dut.state, VSERR);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_csync", csync_o, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_state", dut.state, NOLOCK);
    reset = 1'b0;
    line(100, 8, 1'b0);
    chk("postrst_nolock", dut.state, NOLOCK);
    line(100, 8, 1'b0);
    chk("postrst_lock", dut.state, LINE);
    cediv = 4;
    repeat (3) line(50, 8, 1'b0);
    chk("ce4_line_len", dut.u_meas.line_len, 50);
    chk("ce4_hs_len", dut.u_meas.hs_len, 8);
    line(50, 8, 1'b1);
    window(50, 8, 32, "ce4_gap_clk");
    line(50, 8, 1'b1);
    line(50, 8, 1'b0);
    serr_en = 1'b0;
    line(50, 8, 1'b1);
    chk("toggle_state", dut.state, NOLOCK);
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
